// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, redirect/flush, stall hold,
// wait-state bubbles and a saturating bubble counter.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [0:0] {StBoot, StFetch} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;
  logic [31:0]      pc_plus4;

  // Target is forced word aligned, so its low bits never matter.
  logic unused_tgt;
  assign unused_tgt = ^redirect_target[1:0];

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    imem_req = 1'b0;
    bubble   = 1'b0;

    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          // Flush wins over stall; any word returned this cycle is dropped.
          pc_d    = {redirect_target[31:2], 2'b00};
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          bubble  = 1'b1;
        end else if (stall) begin
          // Hold everything; a returned word is refetched later from the same PC.
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          bubble  = 1'b1;
        end
      end
      default: state_d = StBoot;
    endcase

    if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign bubble_count = cnt_q;

endmodule
